dcache_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single data-cache port. It shares the port between the CPU datapath's load/store path and a loader/debug requester that preloads or inspects data memory. It latches each granted request, drives the cache for exactly one cycle, returns read data with a one-cycle ack pulse, and produces the CPU stall that freezes PC and register-file writes while a CPU access is pending.

---
 rtl/dcache_arbiter_pkg.sv | 19 +
 rtl/dcache_arbiter_rr_pick2.sv | 22 ++
 rtl/dcache_arbiter.sv | 132 +++++++++++++
 tb/tb_dcache_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arbiter_pkg.sv
// rtl/dcache_arbiter_pkg.sv - shared encodings for the data-cache port arbiter
package dcache_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_CPU = 2'd1,
      GNT_LD  = 2'd2
   } state_t;

   // Requester identifiers, also the encoding of last_grant
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

   // Grant state that serves the given requester
   function automatic state_t gnt_state(input logic id);
      return (id == REQ_LD) ? GNT_LD : GNT_CPU;
   endfunction

endpackage

// File: rtl/dcache_arbiter_rr_pick2.sv
// rtl/dcache_arbiter_rr_pick2.sv - two-way round-robin chooser
module rr_pick2
   import dcache_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_id
);

   // A lone request wins outright; a tie goes to whoever was not served last
   always_comb begin
      grant_valid = |req;
      grant_id    = REQ_CPU;
      if (req == 2'b11) begin
         grant_id = ~last;
      end else if (req[REQ_LD]) begin
         grant_id = REQ_LD;
      end
   end

endmodule

// File: rtl/dcache_arbiter.sv
// rtl/dcache_arbiter.sv - shares the single data-cache port between CPU and loader
module dcache_arbiter
   import dcache_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   state_t            state_n;
   logic              last_grant;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;

   // A request seen together with its own ack is the finished transaction
   // still being held; masking it stops it from being granted twice.
   logic cpu_pend;
   logic ld_pend;
   assign cpu_pend = cpu_req & ~cpu_ack;
   assign ld_pend  = ld_req & ~ld_ack;

   logic pick_valid;
   logic pick_id;

   rr_pick2 u_pick (
      .req         ({ld_pend, cpu_pend}),
      .last        (last_grant),
      .grant_valid (pick_valid),
      .grant_id    (pick_id)
   );

   logic grant;
   logic grant_id;

   // Next-state: IDLE arbitrates, a grant state hands over to the other side only
   always_comb begin
      grant    = 1'b0;
      grant_id = REQ_CPU;
      case (state)
         IDLE: begin
            grant    = pick_valid;
            grant_id = pick_id;
         end
         GNT_CPU: begin
            grant    = ld_pend;
            grant_id = REQ_LD;
         end
         GNT_LD: begin
            grant    = cpu_pend;
            grant_id = REQ_CPU;
         end
         default: begin
            grant    = 1'b0;
            grant_id = REQ_CPU;
         end
      endcase
      state_n = grant ? gnt_state(grant_id) : IDLE;
   end

   // State register and round-robin history
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= REQ_LD;
      end else begin
         state <= state_n;
         if (grant) begin
            last_grant <= grant_id;
         end
      end
   end

   // Access registers capture the granted request once; later input changes are ignored
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else if (grant) begin
         we_reg    <= (grant_id == REQ_LD) ? ld_we    : cpu_we;
         addr_reg  <= (grant_id == REQ_LD) ? ld_addr  : cpu_addr;
         wdata_reg <= (grant_id == REQ_LD) ? ld_wdata : cpu_wdata;
      end
   end

   // Completion: capture read data and pulse ack as each grant cycle ends
   always_ff @(posedge clk) begin
      if (!rst) begin
         cpu_ack   <= 1'b0;
         ld_ack    <= 1'b0;
         cpu_rdata <= '0;
         ld_rdata  <= '0;
      end else begin
         cpu_ack <= (state == GNT_CPU);
         ld_ack  <= (state == GNT_LD);
         if (state == GNT_CPU) begin
            cpu_rdata <= mem_rdata;
         end
         if (state == GNT_LD) begin
            ld_rdata <= mem_rdata;
         end
      end
   end

   // The write strobe is gated by reset so an interrupted store never lands
   assign mem_we    = (state != IDLE) & we_reg & rst;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb/tb_dcache_arbiter.sv - scoreboard bench for dcache_arbiter
module tb_dcache_arbiter;
   import dcache_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack, cpu_stall;
   logic        ld_req = 1'b0, ld_we = 1'b0;
   logic [31:0] ld_addr = '0, ld_wdata = '0;
   logic [31:0] ld_rdata;
   logic        ld_ack;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   dcache_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_rdata(ld_rdata), .ld_ack(ld_ack),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Cache model: combinational read, write on the clock edge
   logic [31:0] mem [0:255] = '{default: 32'h0};
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

   // Reference memory, updated in the order requests are issued
   logic [31:0] model_mem [0:255];

   typedef struct { logic we; logic [31:0] data; } exp_t;
   exp_t cpu_q[$];
   exp_t ld_q[$];
   bit   ack_log[$];

   int n_checks = 0;
   int n_fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever an ack is presented
   exp_t mon_e;
   always @(negedge clk) begin
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
      if (!rst) chk("mem_we_in_reset", 32'(mem_we), 32'h0);
      if (cpu_ack) begin
         ack_log.push_back(1'b0);
         if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'h1, 32'h0);
         else begin
            mon_e = cpu_q.pop_front();
            if (!mon_e.we) chk("cpu_rdata", cpu_rdata, mon_e.data);
         end
      end
      if (ld_ack) begin
         ack_log.push_back(1'b1);
         if (ld_q.size() == 0) chk("ld_ack_unexpected", 32'h1, 32'h0);
         else begin
            mon_e = ld_q.pop_front();
            if (!mon_e.we) chk("ld_rdata", ld_rdata, mon_e.data);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that ends the ack cycle
   task automatic cpu_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      e.we = we; e.data = model_mem[a[7:0]];
      if (we) model_mem[a[7:0]] = d;
      cpu_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!cpu_ack && n < 20) begin n++; @(negedge clk); end
      if (!cpu_ack) chk("cpu_ack_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   task automatic ld_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1'b1;
      e.we = we; e.data = model_mem[a[7:0]];
      if (we) model_mem[a[7:0]] = d;
      ld_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!ld_ack && n < 20) begin n++; @(negedge clk); end
      if (!ld_ack) chk("ld_ack_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   exp_t ex;
   int   cg, lg;

   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
      chk("rst_ld_ack", 32'(ld_ack), 32'h0);

      // Uncontended CPU store
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
      ex.we = 1'b1; ex.data = 32'h0; cpu_q.push_back(ex);
      model_mem[8'h10] = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_c0_mem_we", 32'(mem_we), 32'h0);
      chk("t1_c0_stall", 32'(cpu_stall), 32'h1);
      @(negedge clk);
      chk("t1_c1_mem_we", 32'(mem_we), 32'h1);
      chk("t1_c1_mem_addr", mem_addr, 32'h10);
      chk("t1_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t1_c1_stall", 32'(cpu_stall), 32'h1);
      @(negedge clk);
      chk("t1_c2_ack", 32'(cpu_ack), 32'h1);
      chk("t1_c2_mem_we", 32'(mem_we), 32'h0);
      chk("t1_c2_stall", 32'(cpu_stall), 32'h0);
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      chk("t1_c3_ack", 32'(cpu_ack), 32'h0);

      // Simultaneous requests out of reset: CPU first
      do_reset();
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
      ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h5; ld_req = 1'b1;
      ex.we = 1'b0; ex.data = model_mem[8'h10]; cpu_q.push_back(ex);
      ex.we = 1'b1; ex.data = 32'h0; ld_q.push_back(ex);
      model_mem[8'h20] = 32'h5;
      @(negedge clk);
      @(negedge clk);
      chk("t2_c1_mem_addr", mem_addr, 32'h10);
      chk("t2_c1_mem_we", 32'(mem_we), 32'h0);
      @(negedge clk);
      chk("t2_c2_cpu_ack", 32'(cpu_ack), 32'h1);
      chk("t2_c2_ld_ack", 32'(ld_ack), 32'h0);
      chk("t2_c2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("t2_c2_mem_we", 32'(mem_we), 32'h1);
      chk("t2_c2_mem_addr", mem_addr, 32'h20);
      chk("t2_c2_mem_wdata", mem_wdata, 32'h5);
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      chk("t2_c3_ld_ack", 32'(ld_ack), 32'h1);
      chk("t2_c3_cpu_ack", 32'(cpu_ack), 32'h0);
      @(posedge clk); #1 ld_req = 1'b0;
      @(negedge clk);
      chk("t2_c4_ld_ack", 32'(ld_ack), 32'h0);

      // Loader store then CPU load of the same address
      @(posedge clk); #1;
      fork
         begin ld_txn(1'b1, 32'h30, 32'h1234); ld_req = 1'b0; end
         begin @(posedge clk); #1; cpu_txn(1'b0, 32'h30, 32'h0); cpu_req = 1'b0; end
      join
      chk("t4_cpu_rdata", cpu_rdata, 32'h1234);

      // Address change during the grant cycle is ignored
      repeat (2) @(posedge clk);
      #1;
      cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
      ex.we = 1'b0; ex.data = model_mem[8'h10]; cpu_q.push_back(ex);
      @(posedge clk); #1 cpu_addr = 32'h50;
      @(negedge clk);
      chk("t6_mem_addr", mem_addr, 32'h10);
      @(negedge clk);
      chk("t6_ack", 32'(cpu_ack), 32'h1);
      chk("t6_rdata", cpu_rdata, 32'hDEADBEEF);
      @(posedge clk); #1 cpu_req = 1'b0;
      repeat (4) @(posedge clk);

      // Reset dropped during a loader store
      #1;
      ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hBAD0BAD0; ld_req = 1'b1;
      @(posedge clk); #1 rst = 1'b0; ld_req = 1'b0;
      @(negedge clk);
      chk("t5_state_gnt", 32'(dut.state), 32'(GNT_LD));
      chk("t5_mem_we", 32'(mem_we), 32'h0);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("t5_state_idle", 32'(dut.state), 32'(IDLE));
      chk("t5_mem_addr", mem_addr, 32'h0);
      chk("t5_cpu_rdata", cpu_rdata, 32'h0);
      chk("t5_ld_rdata", ld_rdata, 32'h0);
      chk("t5_ld_ack", 32'(ld_ack), 32'h0);
      repeat (3) @(negedge clk);
      chk("t5_no_write", mem[8'h40], 32'h0);

      // Sustained contention: six each, strictly alternating from the CPU
      ack_log.delete();
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 6; i++) cpu_txn(1'b1, 32'h80 + 32'(i), $urandom);
            cpu_req = 1'b0;
         end
         begin
            for (int j = 0; j < 6; j++) ld_txn(1'b0, 32'hC0 + 32'(j), 32'h0);
            ld_req = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      chk("t3_ack_count", 32'(ack_log.size()), 32'd12);
      for (int k = 0; k < ack_log.size(); k++) chk("t3_alternate", 32'(ack_log[k]), 32'(k % 2));

      // Random traffic on disjoint regions
      #1;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               cg = $urandom_range(0, 2);
               if (cg > 0) begin cpu_req = 1'b0; repeat (cg) begin @(posedge clk); #1; end end
               cpu_txn(1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 15)), $urandom);
            end
            cpu_req = 1'b0;
         end
         begin
            for (int j = 0; j < 30; j++) begin
               lg = $urandom_range(0, 2);
               if (lg > 0) begin ld_req = 1'b0; repeat (lg) begin @(posedge clk); #1; end end
               ld_txn(1'($urandom_range(0, 1)), 32'hC0 + 32'($urandom_range(0, 15)), $urandom);
            end
            ld_req = 1'b0;
         end
      join
      repeat (4) @(posedge clk);
      chk("end_cpu_q_empty", 32'(cpu_q.size()), 32'h0);
      chk("end_ld_q_empty", 32'(ld_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
